// File: rtl/adc_sample_uart.sv
// rtl/adc_sample_uart.sv - ADC sample capture FIFO feeding an 8N1 UART transmitter
//
// Ports:
//   clk         system clock, rising edge
//   rst         synchronous active-high reset
//   sample_in   ADC sample, captured while sample_rdy is high
//   sample_rdy  write request, one write per high cycle
//   serial_out  UART TX line, idles high (registered)
//   busy        high while start, data or stop bit is on the line (registered)
//   fifo_level  number of samples currently held in the FIFO
//   overflow    sticky, set when a sample is dropped on a full FIFO

module adc_sample_uart #(
    parameter int DATA_WIDTH      = 8,
    parameter int CLKS_PER_BIT    = 139,
    parameter int FIFO_DEPTH_BITS = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [DATA_WIDTH-1:0]      sample_in,
    input  logic                       sample_rdy,
    output logic                       serial_out,
    output logic                       busy,
    output logic [FIFO_DEPTH_BITS:0]   fifo_level,
    output logic                       overflow
);

    localparam int DEPTH  = 1 << FIFO_DEPTH_BITS;
    localparam int BAUD_W = $clog2(CLKS_PER_BIT);
    localparam int IDX_W  = $clog2(DATA_WIDTH) + 1;
    localparam int LVL_W  = FIFO_DEPTH_BITS + 1;

    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(DATA_WIDTH - 1);
    localparam logic [LVL_W-1:0]  LVL_FULL  = LVL_W'(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP
    } state_t;

    state_t                      state_q, state_d;
    logic [BAUD_W-1:0]           baud_q, baud_d;
    logic [IDX_W-1:0]            idx_q, idx_d;
    logic [DATA_WIDTH-1:0]       shift_q, shift_d;
    logic [FIFO_DEPTH_BITS-1:0]  wr_ptr_q, wr_ptr_d;
    logic [FIFO_DEPTH_BITS-1:0]  rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0]            level_q, level_d;
    logic                        overflow_q, overflow_d;
    logic                        serial_q, serial_d;
    logic                        busy_q, busy_d;
    logic [DATA_WIDTH-1:0]       mem_q [DEPTH];

    logic pop;
    logic push;
    logic drop;
    logic full;

    always_comb begin
        // IDLE pops whenever anything is stored; a pop frees a slot in the
        // same cycle, so a write to a full FIFO is still accepted then.
        full = (level_q == LVL_FULL);
        pop  = (state_q == S_IDLE) && (level_q != '0);
        push = sample_rdy && (!full || pop);
        drop = sample_rdy && full && !pop;

        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        level_d    = level_q;
        overflow_d = overflow_q | drop;

        if (push) begin
            wr_ptr_d = wr_ptr_q + FIFO_DEPTH_BITS'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + FIFO_DEPTH_BITS'(1);
        end
        if (push && !pop) begin
            level_d = level_q + LVL_W'(1);
        end else if (pop && !push) begin
            level_d = level_q - LVL_W'(1);
        end
    end

    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        idx_d   = idx_q;
        shift_d = shift_q;

        case (state_q)
            S_IDLE: begin
                if (pop) begin
                    shift_d = mem_q[rd_ptr_q];
                    baud_d  = '0;
                    idx_d   = '0;
                    state_d = S_START;
                end
            end
            S_START: begin
                if (baud_q == BAUD_LAST) begin
                    baud_d  = '0;
                    state_d = S_DATA;
                end else begin
                    baud_d = baud_q + BAUD_W'(1);
                end
            end
            S_DATA: begin
                if (baud_q == BAUD_LAST) begin
                    baud_d = '0;
                    if (idx_q == IDX_LAST) begin
                        state_d = S_STOP;
                    end else begin
                        shift_d = shift_q >> 1;
                        idx_d   = idx_q + IDX_W'(1);
                    end
                end else begin
                    baud_d = baud_q + BAUD_W'(1);
                end
            end
            S_STOP: begin
                if (baud_q == BAUD_LAST) begin
                    baud_d  = '0;
                    state_d = S_IDLE;
                end else begin
                    baud_d = baud_q + BAUD_W'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Line and busy are registered from the next-state view so they
        // change on the same edge as the state they describe.
        busy_d   = (state_d != S_IDLE);
        serial_d = 1'b1;
        case (state_d)
            S_START: serial_d = 1'b0;
            S_DATA:  serial_d = shift_d[0];
            default: serial_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            baud_q     <= '0;
            idx_q      <= '0;
            shift_q    <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            overflow_q <= 1'b0;
            serial_q   <= 1'b1;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            baud_q     <= baud_d;
            idx_q      <= idx_d;
            shift_q    <= shift_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            overflow_q <= overflow_d;
            serial_q   <= serial_d;
            busy_q     <= busy_d;
        end
    end

    // Storage needs no reset: only slots covered by the level are ever read.
    always_ff @(posedge clk) begin
        if (!rst && push) begin
            mem_q[wr_ptr_q] <= sample_in;
        end
    end

    assign serial_out = serial_q;
    assign busy       = busy_q;
    assign fifo_level = level_q;
    assign overflow   = overflow_q;

endmodule

// File: tb/tb_adc_sample_uart.sv
// tb/tb_adc_sample_uart.sv - directed bench for adc_sample_uart with 4 clocks per bit

module tb_adc_sample_uart;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] sample_in = 8'h00;
    logic       sample_rdy = 1'b0;
    logic       serial_out;
    logic       busy;
    logic [2:0] fifo_level;
    logic       overflow;

    int n_cmp  = 0;
    int n_fail = 0;
    int cyc    = 0;
    int max_lvl;
    bit ovf_seen;

    logic [7:0] rx_q[$];
    int         rx_t_q[$];
    bit         rx_ok_q[$];

    typedef struct {
        logic [7:0] din;
        logic [9:0] line;   // bit i = i-th bit on the wire (0 = start, 9 = stop)
    } vec_t;

    vec_t tbl[5];

    adc_sample_uart #(
        .DATA_WIDTH(8),
        .CLKS_PER_BIT(4),
        .FIFO_DEPTH_BITS(2)
    ) dut (
        .clk(clk),
        .rst(rst),
        .sample_in(sample_in),
        .sample_rdy(sample_rdy),
        .serial_out(serial_out),
        .busy(busy),
        .fifo_level(fifo_level),
        .overflow(overflow)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic track();
        if (int'(fifo_level) > max_lvl) max_lvl = int'(fifo_level);
        if (overflow === 1'b1) ovf_seen = 1'b1;
    endtask

    task automatic pulse(input logic [7:0] d);
        @(negedge clk);
        track();
        sample_rdy = 1'b1;
        sample_in  = d;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            track();
            sample_rdy = 1'b0;
        end
    endtask

    task automatic clear_rx();
        rx_q.delete();
        rx_t_q.delete();
        rx_ok_q.delete();
        max_lvl  = 0;
        ovf_seen = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        sample_rdy = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        clear_rx();
    endtask

    task automatic wait_rx(input int n, input int budget);
        int k;
        k = 0;
        while (rx_q.size() < n && k < budget) begin
            @(negedge clk);
            track();
            k++;
        end
        check("rx_count", rx_q.size(), n);
    endtask

    // Line monitor: decodes every frame, checking start/stop levels, that each
    // bit holds for 4 cycles and that busy stays high for the whole frame.
    initial begin
        logic [7:0] d;
        bit         ok;
        int         st;
        int         w;
        forever begin
            @(negedge clk);
            if (rst === 1'b0 && serial_out === 1'b0) begin
                st = cyc;
                ok = 1'b1;
                d  = 8'h00;
                for (int i = 0; i < 40; i++) begin
                    if (i > 0) @(negedge clk);
                    w = i / 4;
                    if (busy !== 1'b1) ok = 1'b0;
                    if (w == 0 && serial_out !== 1'b0) ok = 1'b0;
                    if (w == 9 && serial_out !== 1'b1) ok = 1'b0;
                    if (w >= 1 && w <= 8) begin
                        if (i % 4 == 0) d[w-1] = serial_out;
                        else if (serial_out !== d[w-1]) ok = 1'b0;
                    end
                end
                rx_q.push_back(d);
                rx_t_q.push_back(st);
                rx_ok_q.push_back(ok);
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [39:0] obs;
        logic [39:0] exp40;
        int          busy_cnt;
        int          k;
        logic [7:0]  exp_b2b [3];
        logic [7:0]  exp_sim [6];

        tbl[0] = '{din: 8'hA5, line: 10'b1101001010};
        tbl[1] = '{din: 8'h00, line: 10'b1000000000};
        tbl[2] = '{din: 8'hFF, line: 10'b1111111110};
        tbl[3] = '{din: 8'h5A, line: 10'b1010110100};
        tbl[4] = '{din: 8'h3C, line: 10'b1001111000};

        max_lvl  = 0;
        ovf_seen = 1'b0;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_serial", serial_out, 1'b1);
        check("rst_busy", busy, 1'b0);
        check("rst_level", fifo_level, 3'd0);
        check("rst_overflow", overflow, 1'b0);
        rst = 1'b0;
        @(negedge clk);

        // Single-sample frames, cycle-exact
        for (int r = 0; r < 5; r++) begin
            @(negedge clk);
            sample_rdy = 1'b1;
            sample_in  = tbl[r].din;
            @(negedge clk);
            sample_rdy = 1'b0;
            check("single_level_after_write", fifo_level, 3'd1);
            check("single_line_before_start", {busy, serial_out}, 2'b01);
            obs = '0;
            busy_cnt = 0;
            for (int i = 0; i < 40; i++) begin
                @(negedge clk);
                obs[i]   = serial_out;
                exp40[i] = tbl[r].line[i/4];
                if (busy === 1'b1) busy_cnt++;
            end
            check("single_frame_bits", obs, exp40);
            check("single_busy_cycles", busy_cnt, 40);
            @(negedge clk);
            check("single_after_serial", serial_out, 1'b1);
            check("single_after_busy", busy, 1'b0);
            check("single_after_level", fifo_level, 3'd0);
        end

        // Back-to-back frames
        do_reset();
        pulse(8'h00);
        pulse(8'hFF);
        pulse(8'h3C);
        idle(1);
        check("b2b_level", fifo_level, 3'd2);
        wait_rx(3, 300);
        exp_b2b = '{8'h00, 8'hFF, 8'h3C};
        for (int i = 0; i < 3; i++) begin
            check("b2b_data", rx_q[i], exp_b2b[i]);
            check("b2b_frame_ok", rx_ok_q[i], 1'b1);
        end
        check("b2b_gap_1", rx_t_q[1] - rx_t_q[0], 41);
        check("b2b_gap_2", rx_t_q[2] - rx_t_q[1], 41);
        check("b2b_overflow", ovf_seen, 1'b0);

        // Overflow: six writes into a depth-4 FIFO while the first frame starts
        do_reset();
        for (int s = 1; s <= 6; s++) pulse(8'(s));
        idle(1);
        check("ovf_flag_set", overflow, 1'b1);
        wait_rx(5, 400);
        idle(60);
        check("ovf_frames_total", rx_q.size(), 5);
        for (int i = 0; i < 5; i++) begin
            check("ovf_data", rx_q[i], 8'(i + 1));
            check("ovf_frame_ok", rx_ok_q[i], 1'b1);
        end
        check("ovf_peak_level", max_lvl, 4);
        check("ovf_sticky", overflow, 1'b1);
        do_reset();
        check("ovf_cleared_by_rst", overflow, 1'b0);

        // Write on the IDLE pop cycle with the FIFO full
        do_reset();
        pulse(8'h11);
        pulse(8'h22);
        pulse(8'h33);
        pulse(8'h44);
        pulse(8'h55);
        idle(1);
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (busy === 1'b1 && k < 100);
        check("sim_idle_reached", busy, 1'b0);
        check("sim_level_full", fifo_level, 3'd4);
        sample_rdy = 1'b1;
        sample_in  = 8'h77;
        @(negedge clk);
        sample_rdy = 1'b0;
        check("sim_level_after", fifo_level, 3'd4);
        check("sim_no_overflow", overflow, 1'b0);
        wait_rx(6, 400);
        exp_sim = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h77};
        for (int i = 0; i < 6; i++) begin
            check("sim_data", rx_q[i], exp_sim[i]);
            check("sim_frame_ok", rx_ok_q[i], 1'b1);
        end
        check("sim_overflow_seen", ovf_seen, 1'b0);

        // Reset in the middle of the DATA state
        do_reset();
        pulse(8'hC3);
        pulse(8'h81);
        idle(15);
        check("midrst_in_frame", busy, 1'b1);
        check("midrst_level_before", fifo_level, 3'd1);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midrst_serial", serial_out, 1'b1);
        check("midrst_busy", busy, 1'b0);
        check("midrst_level", fifo_level, 3'd0);
        idle(50);
        clear_rx();
        pulse(8'h5A);
        idle(1);
        wait_rx(1, 100);
        idle(60);
        check("midrst_frames_total", rx_q.size(), 1);
        check("midrst_data", rx_q[0], 8'h5A);
        check("midrst_frame_ok", rx_ok_q[0], 1'b1);

        // Pointer wrap-around with spaced samples
        do_reset();
        for (int s = 0; s < 10; s++) begin
            pulse(8'h10 + 8'(s));
            idle(44);
        end
        wait_rx(10, 200);
        for (int i = 0; i < 10; i++) begin
            check("wrap_data", rx_q[i], 8'h10 + 8'(i));
            check("wrap_frame_ok", rx_ok_q[i], 1'b1);
        end
        check("wrap_overflow", ovf_seen, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/adc_sample_uart.md
# adc_sample_uart

Downstream consumer of the sigma-delta ADC core. It captures each 8-bit sample qualified by the ADC's `sample_rdy` strobe into a small FIFO. It then transmits the samples LSB-first as 8N1 UART frames on `serial_out`, which lets a host log the converted signal.

## Interface
Parameters:
- `DATA_WIDTH`, 8: sample width; also the number of UART data bits per frame.
- `CLKS_PER_BIT`, 139: clock cycles per UART bit (16 MHz / 115200). Must be ≥ 2.
- `FIFO_DEPTH_BITS`, 2: FIFO holds 2^FIFO_DEPTH_BITS samples.

Ports:
- `clk`, input, 1: single system clock; all logic uses the rising edge.
- `rst`, input, 1: synchronous, active-high reset.
- `sample_in`, input, DATA_WIDTH: ADC sample (the ADC core's `digital_out`).
- `sample_rdy`, input, 1: write request. Each cycle it is high is one write.
- `serial_out`, output, 1: UART TX line; idles high.
- `busy`, output, 1: high while a frame (start, data or stop bit) is on the line.
- `fifo_level`, output, FIFO_DEPTH_BITS+1: number of samples currently stored.
- `overflow`, output, 1: sticky flag, set when a sample is dropped; cleared only by `rst`.

## Operation
- **FIFO.** Circular buffer with read and write pointers of FIFO_DEPTH_BITS bits that wrap modulo depth, plus a level counter.
  - Write: on a cycle with `sample_rdy`=1 and the FIFO not full (after accounting for any same-cycle pop), `sample_in` is stored.
  - Drop: if the FIFO is full and no same-cycle pop occurs, the sample is discarded and `overflow` is set to 1 on the next cycle.
  - Simultaneous pop and write when full: the write is accepted and the level stays at full.
  - Simultaneous pop and write otherwise: the level is unchanged.
- **TX FSM**, states IDLE, START, DATA, STOP:
  - IDLE: `serial_out`=1, `busy`=0. If the level is nonzero, pop the head into an 8-bit shift register, clear the baud counter and bit index, and go to START.
  - START: `serial_out`=0 for CLKS_PER_BIT cycles, then go to DATA.
  - DATA: `serial_out` = shift[0]. Every CLKS_PER_BIT cycles, shift right and increment the bit index. After DATA_WIDTH bits, go to STOP.
  - STOP: `serial_out`=1 for CLKS_PER_BIT cycles, then go to IDLE.
- **Counter widths.**
  - Baud counter: $clog2(CLKS_PER_BIT) bits, counting 0..CLKS_PER_BIT-1.
  - Bit index: $clog2(DATA_WIDTH)+1 bits.
- **Register and data rules.**
  - `serial_out` and `busy` are registered outputs.
  - `busy`=1 in START, DATA and STOP.
  - The popped sample is held in the shift register, so FIFO writes during a frame do not corrupt the frame in flight.

## Timing
- Values during and after reset: `serial_out`=1, `busy`=0, `fifo_level`=0, `overflow`=0, FSM=IDLE, pointers=0. FIFO contents are don't-care.
- Reset is honoured mid-frame. The line returns high on the cycle after `rst` is sampled high, and the partial frame is abandoned.
- Latency into the FIFO: `sample_rdy` sampled at edge N gives `fifo_level` incremented after edge N.
- Latency to the line, FIFO empty and FSM in IDLE: `sample_rdy` at edge N → IDLE pops at edge N+1 → `serial_out`=0 after edge N+1. The start bit appears on the second cycle after the request.
- Frame length is exactly 10·CLKS_PER_BIT cycles, start bit through stop bit.
- Back-to-back frames: STOP exits to IDLE, which holds the line high for one cycle, then the next start bit begins. Frame-to-frame period is 10·CLKS_PER_BIT+1 cycles.
- Storage limit: the FIFO holds 2^FIFO_DEPTH_BITS samples plus one in the shift register.
- Wrap-around: pointers wrap silently, and sample order is preserved across the wrap.

## Test plan
- **Single sample.** CLKS_PER_BIT=4, one pulse with `sample_in`=0xA5.
  - Required: start bit low for 4 cycles beginning 2 cycles after the pulse.
  - Then bits 1,0,1,0,0,1,0,1, 4 cycles each, then stop high for 4 cycles.
  - `busy` high for exactly 40 cycles, `fifo_level` returns to 0.
- **Back-to-back.** Three pulses 0x00, 0xFF, 0x3C on consecutive cycles.
  - Required: three frames in order, each 40 cycles, separated by exactly 1 idle-high cycle.
  - `overflow`=0 throughout.
- **Overflow.** Depth 4, six consecutive pulses 0x01..0x06.
  - Required: 0x01..0x05 transmitted in order, 0x06 dropped.
  - `fifo_level` peaks at 4, and `overflow` rises to 1 and stays 1 until `rst`.
- **Simultaneous full and pop.** Fill the FIFO to 4 while a frame is in flight, then pulse `sample_rdy` with 0x77 on the IDLE pop cycle.
  - Required: 0x77 accepted and transmitted last, `overflow` stays 0.
- **Reset mid-frame.** Assert `rst` for one cycle during the DATA state.
  - Required: `serial_out`=1, `busy`=0, `fifo_level`=0 on the next cycle.
  - A new 0x5A pulse afterwards transmits a clean frame.
- **Wrap-around.** Stream 10 samples 0x10..0x19, spaced 45 cycles apart.
  - Required: all 10 received in order, `overflow`=0.
